// File: rtl/config_sr_loader_if.sv
// Host-side request/status bundle for the configuration shift-register loader.
// The master drives the request fields; the slave (loader) returns status and readback.
interface config_sr_loader_if #(
  parameter int SIZESRSTAT = 88
);
  logic                  START;
  logic                  TARGET;
  logic [SIZESRSTAT-1:0] WDATA;
  logic                  ABORT;
  logic                  BUSY;
  logic                  DONE;
  logic                  ERR;
  logic [SIZESRSTAT-1:0] RDATA;

  modport master (
    output START, TARGET, WDATA, ABORT,
    input  BUSY, DONE, ERR, RDATA
  );

  modport slave (
    input  START, TARGET, WDATA, ABORT,
    output BUSY, DONE, ERR, RDATA
  );
endinterface

// File: rtl/config_sr_loader.sv
// Serial loader for the dual-chain config register: shifts a word in MSB-first and captures the old contents.
// DONE after N+1 cycles; with CFG_SR_VERIFY_EN a second pass checks the write and DONE arrives after 2N+2.
module config_sr_loader #(
  parameter int SIZESRSTAT = 88,
  parameter int SIZESRDYN  = 16,
  parameter int CNTW       = 7
) (
  input  logic              CLK,
  input  logic              RST_N,
  config_sr_loader_if.slave host,
  input  logic              SDO_IN,
  output logic              SELDYN,
  output logic              SELSTAT,
  output logic              SDI
);
  localparam int              PAD    = SIZESRSTAT - SIZESRDYN;
  localparam logic [CNTW-1:0] N_DYN  = CNTW'(SIZESRDYN);
  localparam logic [CNTW-1:0] N_STAT = CNTW'(SIZESRSTAT);

  typedef enum logic [2:0] {IDLE, SHIFT, GAP, VERIFY, FIN} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_tgt;
  logic [CNTW-1:0]       r_n;
  logic [CNTW-1:0]       r_cnt;
  logic [SIZESRSTAT-1:0] r_sh;
  logic [SIZESRSTAT-1:0] r_rx;
  logic [SIZESRSTAT-1:0] r_rdata;
  logic                  r_seldyn;
  logic                  r_selstat;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic                  w_last;
  logic                  w_tgt;
  logic [SIZESRSTAT-1:0] w_rx_nxt;
  logic [SIZESRSTAT-1:0] w_sh_load;
`ifdef CFG_SR_VERIFY_EN
  logic [SIZESRSTAT-1:0] r_tx;
  logic [SIZESRSTAT-1:0] r_cmp;
  logic [SIZESRSTAT-1:0] w_cmp_nxt;
  logic [SIZESRSTAT-1:0] w_tx_al;
`endif

  assign w_last   = (r_cnt == r_n - 1'b1);
  assign w_tgt    = (r_state == IDLE) ? host.TARGET : r_tgt;
  assign w_rx_nxt = {r_rx[SIZESRSTAT-2:0], SDO_IN};
  // Dynamic words are left-aligned so SDI is always the shifter MSB.
  assign w_sh_load = host.TARGET ? host.WDATA
                                 : {host.WDATA[SIZESRDYN-1:0], {PAD{1'b0}}};
`ifdef CFG_SR_VERIFY_EN
  assign w_cmp_nxt = {r_cmp[SIZESRSTAT-2:0], SDO_IN};
  assign w_tx_al   = r_tgt ? r_tx : {r_tx[SIZESRDYN-1:0], {PAD{1'b0}}};
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:   if (host.START) w_state_nxt = SHIFT;
      SHIFT: begin
        if (host.ABORT) w_state_nxt = FIN;
`ifdef CFG_SR_VERIFY_EN
        else if (w_last) w_state_nxt = GAP;
      end
      GAP:    w_state_nxt = host.ABORT ? FIN : VERIFY;
      VERIFY: if (host.ABORT || w_last) w_state_nxt = FIN;
`else
        else if (w_last) w_state_nxt = FIN;
      end
`endif
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_tgt     <= 1'b0;
      r_n       <= '0;
      r_cnt     <= '0;
      r_sh      <= '0;
      r_rx      <= '0;
      r_rdata   <= '0;
      r_seldyn  <= 1'b0;
      r_selstat <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
`ifdef CFG_SR_VERIFY_EN
      r_tx      <= '0;
      r_cmp     <= '0;
`endif
    end else begin
      r_seldyn  <= 1'b0;
      r_selstat <= 1'b0;
      if (w_state_nxt == SHIFT || w_state_nxt == VERIFY) begin
        r_seldyn  <= ~w_tgt;
        r_selstat <= w_tgt;
      end
      r_busy <= (w_state_nxt != IDLE);
      r_done <= (w_state_nxt == FIN);
      case (r_state)
        IDLE: if (host.START) begin
          r_tgt <= host.TARGET;
          r_n   <= host.TARGET ? N_STAT : N_DYN;
          r_cnt <= '0;
          r_sh  <= w_sh_load;
          r_rx  <= '0;
          r_err <= 1'b0;
`ifdef CFG_SR_VERIFY_EN
          r_tx  <= host.TARGET ? host.WDATA
                               : {{PAD{1'b0}}, host.WDATA[SIZESRDYN-1:0]};
`endif
        end
        SHIFT: begin
          r_rx  <= w_rx_nxt;
          r_sh  <= r_sh << 1;
          r_cnt <= (w_state_nxt == SHIFT) ? r_cnt + 1'b1 : '0;
          if (w_state_nxt == FIN) begin
            r_rdata <= w_rx_nxt;
            r_err   <= host.ABORT;
          end
        end
`ifdef CFG_SR_VERIFY_EN
        GAP: begin
          r_sh  <= w_tx_al;
          r_cmp <= '0;
          if (host.ABORT) begin
            r_rdata <= r_rx;
            r_err   <= 1'b1;
          end
        end
        VERIFY: begin
          r_cmp <= w_cmp_nxt;
          r_sh  <= r_sh << 1;
          r_cnt <= (w_state_nxt == VERIFY) ? r_cnt + 1'b1 : '0;
          if (w_state_nxt == FIN) begin
            r_rdata <= r_rx;
            r_err   <= host.ABORT || (w_cmp_nxt != r_tx);
          end
        end
`endif
        default: ;
      endcase
      // An aborted word must not leave a stale bit on SDI.
      if (w_state_nxt == FIN) r_sh <= '0;
    end
  end

  assign SELDYN     = r_seldyn;
  assign SELSTAT    = r_selstat;
  assign SDI        = r_sh[SIZESRSTAT-1];
  assign host.BUSY  = r_busy;
  assign host.DONE  = r_done;
  assign host.ERR   = r_err;
  assign host.RDATA = r_rdata;
endmodule

// File: tb/tb_config_sr_loader.sv
// Scoreboarded bench: a chain model answers on SDO_IN, an operation-level reference predicts each DONE.
module tb_config_sr_loader;
  localparam int S = 88;
  localparam int D = 16;
  localparam logic [S-1:0] STAT_INIT = {9'h000, 10'h3FF, 53'h0A_BCDE_F012_3456, 16'hA554};
`ifdef CFG_SR_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  typedef struct {
    logic [S-1:0] rdata;
    logic         err;
    int           done_cyc;
    int           n_dyn;
    int           n_stat;
    logic [D-1:0] ch_dyn;
    logic [S-1:0] ch_stat;
  } exp_t;

  logic CLK = 1'b0;
  logic RST_N;
  logic SDO_IN, SELDYN, SELSTAT, SDI;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  // External register contents (environment) and the expected contents (reference).
  logic [D-1:0] ch_dyn   = 16'h4000;
  logic [S-1:0] ch_stat  = STAT_INIT;
  logic [D-1:0] ref_dyn  = 16'h4000;
  logic [S-1:0] ref_stat = STAT_INIT;
  bit           force0   = 1'b0;

  config_sr_loader_if #(.SIZESRSTAT(S)) ifc ();

  config_sr_loader #(.SIZESRSTAT(S), .SIZESRDYN(D), .CNTW(7)) dut (
    .CLK(CLK), .RST_N(RST_N), .host(ifc), .SDO_IN(SDO_IN),
    .SELDYN(SELDYN), .SELSTAT(SELSTAT), .SDI(SDI)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK) begin
    if (SELDYN)  ch_dyn  <= {ch_dyn[D-2:0], SDI};
    if (SELSTAT) ch_stat <= {ch_stat[S-2:0], SDI};
  end
  assign SDO_IN = force0 ? 1'b0 : (SELDYN ? ch_dyn[D-1] : (SELSTAT ? ch_stat[S-1] : 1'b0));

  task automatic chk_v(input string name, input logic [S-1:0] act, input logic [S-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  int seen_dyn = 0;
  int seen_stat = 0;
  bit overlap = 1'b0;
  always @(negedge CLK) begin
    exp_t e;
    if (!RST_N) begin
      seen_dyn = 0; seen_stat = 0; overlap = 1'b0;
    end else begin
      if (SELDYN) seen_dyn++;
      if (SELSTAT) seen_stat++;
      if (SELDYN && SELSTAT) overlap = 1'b1;
      if (ifc.DONE) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: DONE=1 at cycle %0d, required no pending operation", cyc);
        end else begin
          e = sb.pop_front();
          chk_v("rdata", ifc.RDATA, e.rdata);
          chk_i("err", int'(ifc.ERR), int'(e.err));
          chk_i("done_cycle", cyc, e.done_cyc);
          chk_i("seldyn_cycles", seen_dyn, e.n_dyn);
          chk_i("selstat_cycles", seen_stat, e.n_stat);
          chk_i("sel_overlap", int'(overlap), 0);
          chk_v("chain_dyn", S'(ch_dyn), S'(e.ch_dyn));
          chk_v("chain_stat", ch_stat, e.ch_stat);
        end
        seen_dyn = 0; seen_stat = 0; overlap = 1'b0;
      end
    end
  end

  task automatic drain(input int budget);
    int t = 0;
    while (sb.size() != 0 && t < budget) begin
      @(negedge CLK);
      t++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: %0d operations pending after %0d cycles, required 0", sb.size(), budget);
      sb.delete();
    end
  endtask

  // abort_at: shift-cycle index (0-based) at which ABORT is raised, or -1 for none.
  task automatic run_op(input bit tgt, input logic [S-1:0] wd, input int abort_at,
                        input bit abort_start, input bit poke);
    int n, k, s, t, sel;
    exp_t e;
    logic [S-1:0] old, tx, mask, nw;
    n    = tgt ? S : D;
    mask = {S{1'b1}} >> (S - n);
    old  = tgt ? ref_stat : S'(ref_dyn);
    tx   = wd & mask;
    @(negedge CLK);
    k = cyc;
    ifc.START = 1'b1; ifc.TARGET = tgt; ifc.WDATA = wd; ifc.ABORT = abort_start;
    if (abort_at < 0) begin
      nw         = tx;
      e.err      = VERIFY && force0 && (tx != '0);
      e.rdata    = force0 ? '0 : old;
      e.done_cyc = VERIFY ? k + 2 * n + 2 : k + n + 1;
      sel        = VERIFY ? 2 * n : n;
    end else begin
      s          = abort_at + 1;
      nw         = ((old << s) | (tx >> (n - s))) & mask;
      e.err      = 1'b1;
      e.rdata    = force0 ? '0 : old >> (n - s);
      e.done_cyc = k + s + 1;
      sel        = s;
    end
    e.n_dyn  = tgt ? 0 : sel;
    e.n_stat = tgt ? sel : 0;
    if (tgt) ref_stat = nw;
    else     ref_dyn  = nw[D-1:0];
    e.ch_dyn  = ref_dyn;
    e.ch_stat = ref_stat;
    sb.push_back(e);
    @(negedge CLK);
    ifc.START = 1'b0;
    ifc.ABORT = (abort_at == 0);
    chk_i("busy_after_start", int'(ifc.BUSY), 1);
    if (abort_at >= 1) begin
      t = 0;
      while (cyc != k + 1 + abort_at && t < 200) begin
        @(negedge CLK);
        t++;
      end
      ifc.ABORT = 1'b1;
    end
    if (abort_at >= 0) begin
      @(negedge CLK);
      ifc.ABORT = 1'b0;
    end
    if (poke) begin
      @(negedge CLK);
      ifc.START = 1'b1; ifc.TARGET = ~tgt; ifc.WDATA = ~wd;
      @(negedge CLK);
      ifc.START = 1'b0;
    end
    drain(2 * S + 40);
    @(negedge CLK);
    chk_i("busy_after_done", int'(ifc.BUSY), 0);
  endtask

  task automatic reset_mid(input logic [S-1:0] wd);
    int k, t;
    @(negedge CLK);
    k = cyc;
    ifc.START = 1'b1; ifc.TARGET = 1'b1; ifc.WDATA = wd; ifc.ABORT = 1'b0;
    @(negedge CLK);
    ifc.START = 1'b0;
    t = 0;
    while (cyc != k + 40 && t < 200) begin
      @(negedge CLK);
      t++;
    end
    RST_N = 1'b0;
    #1;
    chk_i("rst_mid_seldyn", int'(SELDYN), 0);
    chk_i("rst_mid_selstat", int'(SELSTAT), 0);
    chk_i("rst_mid_sdi", int'(SDI), 0);
    chk_i("rst_mid_busy", int'(ifc.BUSY), 0);
    chk_i("rst_mid_done", int'(ifc.DONE), 0);
    chk_v("rst_mid_rdata", ifc.RDATA, '0);
    // 39 shift edges completed before reset; the chain keeps them.
    ref_stat = (ref_stat << 39) | (wd >> (S - 39));
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, required summary before it");
    $fatal(1);
  end

  initial begin
    RST_N = 1'b1;
    ifc.START = 1'b0; ifc.TARGET = 1'b0; ifc.WDATA = '0; ifc.ABORT = 1'b0;
    #2 RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    chk_i("rst_seldyn", int'(SELDYN), 0);
    chk_i("rst_selstat", int'(SELSTAT), 0);
    chk_i("rst_sdi", int'(SDI), 0);
    chk_i("rst_busy", int'(ifc.BUSY), 0);
    chk_i("rst_done", int'(ifc.DONE), 0);
    chk_i("rst_err", int'(ifc.ERR), 0);
    chk_v("rst_rdata", ifc.RDATA, '0);
    RST_N = 1'b1;

    run_op(1'b0, S'(16'hA5C3), -1, 1'b0, 1'b1);
    chk_v("dyn_first_readback", ifc.RDATA, S'(16'h4000));
    run_op(1'b0, S'(16'h1234), -1, 1'b1, 1'b0);
    chk_v("dyn_second_readback", ifc.RDATA, S'(16'hA5C3));
    run_op(1'b1, S'({$urandom, $urandom, $urandom}), -1, 1'b0, 1'b1);
    chk_v("stat_readback", ifc.RDATA, STAT_INIT);
    run_op(1'b1, S'({$urandom, $urandom, $urandom}), 5, 1'b0, 1'b0);
    chk_i("abort_err_held", int'(ifc.ERR), 1);
`ifdef CFG_SR_VERIFY_EN
    run_op(1'b0, S'(16'h00FF), -1, 1'b0, 1'b0);
    force0 = 1'b1;
    run_op(1'b0, S'(16'h00FF), -1, 1'b0, 1'b0);
    force0 = 1'b0;
`endif
    reset_mid(S'({$urandom, $urandom, $urandom}));
    run_op(1'b1, S'({$urandom, $urandom, $urandom}), -1, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      bit tg;
      int ab;
      tg = 1'($urandom_range(0, 1));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, tg ? S - 1 : D - 1)) : -1;
      run_op(tg, S'({$urandom, $urandom, $urandom}), ab, 1'($urandom_range(0, 1)),
             (ab < 0) && ($urandom_range(0, 1) == 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
